// File: rtl/imem_loader.sv
//------------------------------------------------------------------------------
// imem_loader
// Loads a program image from a byte stream into instruction memory while
// holding the core. Stream format: LEN_LO, LEN_HI (word count N), 4*N data
// bytes (little-endian words), one XOR checksum byte over the data bytes.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : one-cycle request to begin a load (honoured in IDLE/DONE/ERR)
//   byte_valid : upstream byte present on byte_data
//   byte_data  : upstream stream byte
//   byte_ready : loader accepts a byte this cycle
//   wr_en      : one-cycle instruction-memory write strobe
//   wr_addr    : byte address of the write (4 * word index)
//   wr_data    : instruction word to write
//   cpu_hold   : hold core fetch while loading
//   busy       : load in progress
//   done       : last load completed with a good checksum
//   error      : last load aborted (bad length or bad checksum)
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module imem_loader #(
  parameter int unsigned DEPTH = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [7:0]  r_len_lo;
  logic [15:0] r_len;
  logic [15:0] r_word_idx;   // index of the next word to be written
  logic [1:0]  r_byte_idx;   // byte position within the current word
  logic [23:0] r_asm;        // lower three bytes of the word being assembled
  logic [7:0]  r_csum;
  logic        r_wr_en;
  logic [31:0] r_wr_addr;
  logic [31:0] r_wr_data;

  logic        w_active;
  logic        w_xfer;
  logic [15:0] w_len;
  logic        w_len_ok;
  logic        w_all_issued;
  logic        w_csum_ok;

  assign w_active     = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                        (r_state == S_DATA) || (r_state == S_CHECK);
  assign w_xfer       = byte_valid && w_active;
  assign w_len        = {byte_data, r_len_lo};
  assign w_len_ok     = (w_len != 16'd0) && ({16'd0, w_len} <= DEPTH);
  assign w_all_issued = (r_word_idx == r_len);
  assign w_csum_ok    = (byte_data == r_csum);

  assign byte_ready = w_active;
  assign busy       = w_active;
  assign cpu_hold   = w_active;
  assign done       = (r_state == S_DONE);
  assign error      = (r_state == S_ERR);
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // DATA is held for one extra cycle after the last word completes so the
  // registered wr_en pulse for that word is never visible in CHECK. A byte
  // transferring in that cycle is already the checksum byte and is judged
  // directly, so stream behaviour is unchanged.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_next = S_LEN0;
      S_LEN0:  if (w_xfer) w_next = S_LEN1;
      S_LEN1:  if (w_xfer) w_next = w_len_ok ? S_DATA : S_ERR;
      S_DATA: begin
        if (w_all_issued) begin
          if (w_xfer) w_next = w_csum_ok ? S_DONE : S_ERR;
          else        w_next = S_CHECK;
        end
      end
      S_CHECK: if (w_xfer) w_next = w_csum_ok ? S_DONE : S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len_lo   <= '0;
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_asm      <= '0;
      r_csum     <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_asm      <= '0;
            r_csum     <= '0;
          end
        end
        S_LEN0: if (w_xfer) r_len_lo <= byte_data;
        S_LEN1: if (w_xfer) r_len <= w_len;
        S_DATA: begin
          if (w_xfer && !w_all_issued) begin
            r_csum     <= r_csum ^ byte_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_wr_en    <= 1'b1;
              r_wr_data  <= {byte_data, r_asm};
              r_wr_addr  <= {14'd0, r_word_idx, 2'b00};
              r_word_idx <= r_word_idx + 16'd1;
            end else begin
              r_asm <= {byte_data, r_asm[23:8]};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps

module tb_imem_loader;

  localparam int unsigned DEPTH = 128;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    string        name;
    logic [87:0]  bytes;   // byte i at [8*i +: 8]
    int           nb;
    int           glo;
    int           ghi;
    logic         exp_done;
    logic         exp_err;
    int           exp_nw;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int illegal_wr = 0;

  logic [63:0] got_q[$];   // observed writes {addr, data}
  logic [63:0] exp_q[$];   // model writes {addr, data}
  logic        m_done;
  logic        m_err;

  // wr_en is a full-cycle pulse, so sampling at negedge records each write once
  always @(negedge clk) begin
    if (wr_en) begin
      got_q.push_back({wr_addr, wr_data});
      if (!busy || done || error) illegal_wr++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: parse the whole stream as an image.
  task automatic model_run(input bq_t s);
    int unsigned n;
    logic [7:0]  cs;
    logic [31:0] w;
    exp_q.delete();
    n = {s[1], s[0]};
    if (n == 0 || n > DEPTH) begin
      m_done = 1'b0;
      m_err  = 1'b1;
      return;
    end
    cs = 8'h00;
    for (int unsigned i = 0; i < n; i++) begin
      w = {s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]};
      exp_q.push_back({32'(4 * i), w});
      cs = cs ^ s[2+4*i] ^ s[2+4*i+1] ^ s[2+4*i+2] ^ s[2+4*i+3];
    end
    m_done = (s[2+4*n] == cs);
    m_err  = !m_done;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_bytes(input bq_t s, input int first, input int count,
                            input int glo, input int ghi, output int sent);
    int gaps;
    sent = 0;
    for (int i = first; i < first + count; i++) begin
      gaps = $urandom_range(ghi, glo);
      repeat (gaps) begin
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
      end
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = s[i];
      if (!byte_ready) begin
        byte_valid = 1'b0;
        return;
      end
      @(posedge clk);
      sent++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_end(input string nm);
    int k = 0;
    while (!(done || error) && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) chk({nm, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic finish_check(input string nm);
    logic [63:0] g, e;
    chk({nm, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      g = got_q[i];
      e = exp_q[i];
      chk($sformatf("%s_addr%0d", nm, i), g[63:32], e[63:32]);
      chk($sformatf("%s_data%0d", nm, i), g[31:0], e[31:0]);
    end
    chk({nm, "_done"},  32'(done),       32'(m_done));
    chk({nm, "_error"}, 32'(error),      32'(m_err));
    chk({nm, "_busy"},  32'(busy),       32'd0);
    chk({nm, "_hold"},  32'(cpu_hold),   32'd0);
    chk({nm, "_ready"}, 32'(byte_ready), 32'd0);
    chk({nm, "_wren"},  32'(wr_en),      32'd0);
  endtask

  task automatic run_load(input string nm, input bq_t s, input int glo, input int ghi);
    int sent;
    got_q.delete();
    model_run(s);
    pulse_start();
    send_bytes(s, 0, s.size(), glo, ghi, sent);
    wait_end(nm);
    finish_check(nm);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_ready"}, 32'(byte_ready), 32'd0);
    chk({nm, "_wren"},  32'(wr_en),      32'd0);
    chk({nm, "_addr"},  wr_addr,         32'd0);
    chk({nm, "_data"},  wr_data,         32'd0);
    chk({nm, "_busy"},  32'(busy),       32'd0);
    chk({nm, "_hold"},  32'(cpu_hold),   32'd0);
    chk({nm, "_done"},  32'(done),       32'd0);
    chk({nm, "_error"}, 32'(error),      32'd0);
  endtask

  function automatic bq_t make_image(input int unsigned n, input logic corrupt);
    bq_t s;
    logic [7:0] cs = 8'h00;
    logic [7:0] b;
    s.push_back(n[7:0]);
    s.push_back(n[15:8]);
    for (int unsigned i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      s.push_back(b);
      cs = cs ^ b;
    end
    if (corrupt) cs = cs ^ 8'(1 << $urandom_range(7, 0));
    s.push_back(cs);
    return s;
  endfunction

  initial begin
    vec_t vecs[5];
    bq_t  s, basic;
    logic [63:0] g;
    int   sent;
    int unsigned n;
    logic [87:0] basic_bits;

    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;

    vecs[0] = '{"basic",  88'h68_04_81_26_23_fb_01_01_13_00_02, 11, 0, 0, 1'b1, 1'b0, 2};
    vecs[1] = '{"gap3",   88'h68_04_81_26_23_fb_01_01_13_00_02, 11, 3, 3, 1'b1, 1'b0, 2};
    vecs[2] = '{"badcs",  88'h69_04_81_26_23_fb_01_01_13_00_02, 11, 0, 0, 1'b0, 1'b1, 2};
    vecs[3] = '{"len129", 88'h00_81, 2, 0, 0, 1'b0, 1'b1, 0};
    vecs[4] = '{"len0",   88'h00_00, 2, 0, 0, 1'b0, 1'b1, 0};

    basic_bits = vecs[0].bytes;
    for (int i = 0; i < 11; i++) basic.push_back(basic_bits[8*i +: 8]);

    #12;
    check_all_zero("reset");
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("idle");

    foreach (vecs[v]) begin
      s.delete();
      for (int i = 0; i < vecs[v].nb; i++) s.push_back(vecs[v].bytes[8*i +: 8]);
      run_load(vecs[v].name, s, vecs[v].glo, vecs[v].ghi);
      chk({vecs[v].name, "_tbl_done"}, 32'(done),  32'(vecs[v].exp_done));
      chk({vecs[v].name, "_tbl_err"},  32'(error), 32'(vecs[v].exp_err));
      chk({vecs[v].name, "_tbl_nw"},   32'(got_q.size()), 32'(vecs[v].exp_nw));
      if (vecs[v].exp_nw == 2 && got_q.size() == 2) begin
        g = got_q[0];
        chk({vecs[v].name, "_w0"}, g[31:0], 32'hfb010113);
        g = got_q[1];
        chk({vecs[v].name, "_a1"}, g[63:32], 32'h00000004);
        chk({vecs[v].name, "_w1"}, g[31:0], 32'h04812623);
      end
    end

    // Reset mid-load (after word 0 completes, and with a partial word pending)
    for (int c = 0; c < 2; c++) begin
      int cut = (c == 0) ? 6 : 8;
      got_q.delete();
      pulse_start();
      send_bytes(basic, 0, cut, 0, 0, sent);
      #2 rst = 1'b1;
      #1 check_all_zero($sformatf("async_rst%0d", cut));
      chk($sformatf("pre_rst_writes%0d", cut), 32'(got_q.size()), 32'd1);
      got_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk($sformatf("no_wr_after_rst%0d", cut), 32'(got_q.size()), 32'd0);
      run_load($sformatf("after_rst%0d", cut), basic, 0, 1);
    end

    // start during DATA is ignored
    got_q.delete();
    model_run(basic);
    pulse_start();
    send_bytes(basic, 0, 4, 0, 0, sent);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_in_data_busy", 32'(busy), 32'd1);
    send_bytes(basic, 4, 7, 0, 1, sent);
    wait_end("start_in_data");
    finish_check("start_in_data");

    // start in DONE re-enters LEN0
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("restart_done",  32'(done),       32'd0);
    chk("restart_error", 32'(error),      32'd0);
    chk("restart_busy",  32'(busy),       32'd1);
    chk("restart_ready", 32'(byte_ready), 32'd1);
    run_load("restart_load", basic, 0, 0);

    // boundary: N = 1 and N = DEPTH
    run_load("n1", make_image(1, 1'b0), 0, 0);
    run_load("ndepth", make_image(DEPTH, 1'b0), 0, 0);

    // randomized images against the model
    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(9, 0) == 0) begin
        n = ($urandom_range(1, 0) == 1) ? 0 : DEPTH + 1 + $urandom_range(50, 0);
        s.delete();
        s.push_back(n[7:0]);
        s.push_back(n[15:8]);
      end else begin
        n = $urandom_range(6, 1);
        s = make_image(n, $urandom_range(3, 0) == 0);
      end
      run_load($sformatf("rand%0d", t), s, 0, $urandom_range(3, 0));
    end

    chk("wr_en_outside_load", 32'(illegal_wr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 128, meaning instruction-memory depth in 32-bit words.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a program load.
REQ-005 SHALL have port byte_valid  input  1  upstream byte present on byte_data.
REQ-006 SHALL have port byte_data  input  8  upstream load-stream byte.
REQ-007 SHALL have port byte_ready  output  1  loader accepts byte this cycle.
REQ-008 SHALL have port wr_en  output  1  instruction-memory word write strobe.
REQ-009 SHALL have port wr_addr  output  32  byte address of write; word index = wr_addr >> 2.
REQ-010 SHALL have port wr_data  output  32  instruction word to write.
REQ-011 SHALL have port cpu_hold  output  1  holds core PC/fetch while loading.
REQ-012 SHALL have port busy  output  1  load in progress.
REQ-013 SHALL have port done  output  1  last load completed with good checksum.
REQ-014 SHALL have port error  output  1  last load aborted.

Function
REQ-015 SHALL transfer a byte only in a cycle where byte_valid and byte_ready are both 1.
REQ-016 SHALL parse the stream as: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes, then one checksum byte.
REQ-017 SHALL assemble each instruction word little-endian: first data byte = bits 7:0, fourth = bits 31:24.
REQ-018 SHALL implement states IDLE, LEN0, LEN1, DATA, CHECK, DONE, ERR.
REQ-019 SHALL go IDLE/DONE/ERR -> LEN0 on start; clear done and error; zero the word counter and checksum.
REQ-020 SHALL ignore start while in LEN0, LEN1, DATA or CHECK.
REQ-021 SHALL go LEN0 -> LEN1 on low-byte transfer; LEN1 -> DATA on high-byte transfer when 1 <= N <= DEPTH, else -> ERR.
REQ-022 SHALL drive byte_ready = 1 exactly in LEN0, LEN1, DATA and CHECK; 0 otherwise.
REQ-023 SHALL, on the fourth byte of a word transferring, pulse wr_en for exactly the next cycle, with wr_data = assembled word and wr_addr = 4*word_index (registered outputs).
REQ-024 SHALL write word indices 0..N-1 in order, with no gaps and no repeats.
REQ-025 SHALL go DATA -> CHECK after the write of word N-1 is issued.
REQ-026 SHALL keep a running XOR checksum over data bytes only, excluding the length bytes.
REQ-027 SHALL go CHECK -> DONE on transfer when byte_data equals the checksum, else -> ERR.
REQ-028 SHALL tolerate arbitrary byte_valid gaps with no change in result or write order.
REQ-029 SHALL drive busy = cpu_hold = 1 in LEN0..CHECK; done = 1 only in DONE; error = 1 only in ERR.
REQ-030 SHALL NOT roll back words already written on a checksum error; error alone flags the image invalid.
REQ-031 SHALL never drive wr_en while in IDLE, LEN0, LEN1, CHECK, DONE or ERR.

Reset
REQ-032 SHALL, on rst high, go to IDLE immediately regardless of clk, including mid-load.
REQ-033 SHALL reset byte_ready, wr_en, busy, cpu_hold, done and error to 0, and wr_addr and wr_data to 0x00000000.
REQ-034 SHALL discard a partially assembled word on reset and SHALL NOT write it after reset.

Verification
REQ-035 SHALL pass: start; bytes 02 00 13 01 01 fb 23 26 81 04 68 -> wr_en at addr 0x0 data 0xfb010113, then addr 0x4 data 0x04812623; done=1, error=0, cpu_hold=0.
REQ-036 SHALL pass: same stream with byte_valid low 3 cycles between every byte -> identical writes and done=1.
REQ-037 SHALL pass: start; bytes 81 00 -> ERR, error=1, byte_ready=0, no wr_en; same with 00 00.
REQ-038 SHALL pass: REQ-035 stream with checksum byte 0x69 -> both words written, then error=1, done=0.
REQ-039 SHALL pass: rst asserted after the 6th byte -> all outputs 0 asynchronously, no further wr_en; a following full load succeeds.
REQ-040 SHALL pass: start pulsed during DATA -> ignored, load completes normally; start in DONE -> done clears, LEN0 entered.
